// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared types for the cache-to-memory controller: RAM status
//               encoding, controller FSM states, response-source tag and
//               the bit positions of the arbiter grant vector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    // Status reported by the RAM model each cycle
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Memory controller states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        IACC = 3'd1,
        DRD  = 3'd2,
        DWR  = 3'd3,
        RESP = 3'd4
    } mctrl_state_t;

    // Which cache the current RESP cycle answers
    typedef enum logic {
        RESP_I = 1'b0,
        RESP_D = 1'b1
    } resp_src_t;

    // Grant one-hot layout produced by mem_arb_sel
    localparam int c_GNT_W   = 3;
    localparam int c_GNT_I   = 0;
    localparam int c_GNT_DRD = 1;
    localparam int c_GNT_DWR = 2;

endpackage : cpu_types_pkg

`default_nettype wire

// File: rtl/cache_mem_ctrl_arb.sv
// ============================================================================
// Module      : mem_arb_sel
// Description : Combinational request arbiter for the memory controller.
//               Priority is write, then data read, then instruction read,
//               except that a pending instruction request wins once the
//               starvation count has reached STARVE_LIMIT.
// Ports       : iREN, dREN, dWEN  - cache request enables
//               starve_cnt        - consecutive data grants while iREN pending
//               grant             - one-hot grant (see cpu_types_pkg c_GNT_*)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_sel
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic               iREN,
    input  logic               dREN,
    input  logic               dWEN,
    input  logic [CNT_W-1:0]   starve_cnt,
    output logic [c_GNT_W-1:0] grant
);

    localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'(STARVE_LIMIT);

    logic w_starved;

    assign w_starved = iREN && (starve_cnt == c_LIMIT);

    always_comb begin
        grant = '0;
        if (w_starved) begin
            grant[c_GNT_I] = 1'b1;
        end else if (dWEN) begin
            // A write also wins over a simultaneous dREN, which resolves the
            // illegal dREN&dWEN combination in favour of the write.
            grant[c_GNT_DWR] = 1'b1;
        end else if (dREN) begin
            grant[c_GNT_DRD] = 1'b1;
        end else if (iREN) begin
            grant[c_GNT_I] = 1'b1;
        end
    end

endmodule : mem_arb_sel

`default_nettype wire

// File: rtl/cache_mem_ctrl.sv
// ============================================================================
// Module      : cache_mem_ctrl
// Description : Memory-side responder for the icache and dcache request
//               interfaces. Arbitrates (data first, with a starvation guard
//               for instruction fetches), runs one transaction at a time on
//               the single-ported RAM and answers by dropping iwait or dwait
//               for exactly one cycle.
// Ports       : CLK, nRST                  - clock, async active-low reset
//               iREN, iaddr, iwait, iload  - icache interface
//               dREN, dWEN, daddr, dstore,
//               dwait, dload               - dcache interface
//               ramREN, ramWEN, ramaddr,
//               ramstore, ramload, ramstate- RAM interface
//               timeout_err                - sticky RAM timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_mem_ctrl
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic        CLK,
    input  logic        nRST,
    // icache
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    // dcache
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    // RAM
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    // status
    output logic        timeout_err
);

    localparam int c_SCNT_W = $clog2(STARVE_LIMIT + 1);
    localparam int c_TCNT_W = $clog2(TIMEOUT + 1);

    localparam logic [c_SCNT_W-1:0] c_SCNT_MAX = c_SCNT_W'(STARVE_LIMIT);
    localparam logic [c_TCNT_W-1:0] c_TCNT_MAX = c_TCNT_W'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // State and holding registers
    // ------------------------------------------------------------------
    mctrl_state_t          r_state;
    resp_src_t             r_src;
    logic [31:0]           r_addr;
    logic [31:0]           r_store;
    logic                  r_ren;
    logic                  r_wen;
    logic [c_SCNT_W-1:0]   r_scnt;
    logic [c_TCNT_W-1:0]   r_tcnt;

    logic [c_GNT_W-1:0]    w_grant;
    ramstate_t             w_rstate;
    logic                  w_req_held;

    assign w_rstate = ramstate_t'(ramstate);

    // ------------------------------------------------------------------
    // Arbiter
    // ------------------------------------------------------------------
    mem_arb_sel #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (c_SCNT_W)
    ) u_arb (
        .iREN       (iREN),
        .dREN       (dREN),
        .dWEN       (dWEN),
        .starve_cnt (r_scnt),
        .grant      (w_grant)
    );

    // Enable of whichever requester owns the transaction in flight; a drop
    // before ACCESS abandons the transaction.
    always_comb begin
        w_req_held = 1'b0;
        case (r_state)
            IACC:    w_req_held = iREN;
            DRD:     w_req_held = dREN;
            DWR:     w_req_held = dWEN;
            default: w_req_held = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // RAM-side outputs come only from the holding registers, so the live
    // cache ports may change freely while a transaction is in flight.
    // They are forced to zero whenever no request is active.
    // ------------------------------------------------------------------
    assign ramREN   = r_ren;
    assign ramWEN   = r_wen;
    assign ramaddr  = (r_ren | r_wen) ? r_addr  : 32'd0;
    assign ramstore = r_wen           ? r_store : 32'd0;

    // Wait lines are low only during RESP, on the side that owns it.
    assign iwait = !((r_state == RESP) && (r_src == RESP_I));
    assign dwait = !((r_state == RESP) && (r_src == RESP_D));

    // ------------------------------------------------------------------
    // Controller FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= IDLE;
            r_src       <= RESP_I;
            r_addr      <= 32'd0;
            r_store     <= 32'd0;
            r_ren       <= 1'b0;
            r_wen       <= 1'b0;
            r_scnt      <= '0;
            r_tcnt      <= '0;
            iload       <= 32'd0;
            dload       <= 32'd0;
            timeout_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // No pending fetch means nothing is being starved.
                    if (!iREN) begin
                        r_scnt <= '0;
                    end

                    if (w_grant[c_GNT_I]) begin
                        r_state <= IACC;
                        r_src   <= RESP_I;
                        r_addr  <= iaddr;
                        r_ren   <= 1'b1;
                        r_tcnt  <= '0;
                        r_scnt  <= '0;
                    end else if (w_grant[c_GNT_DWR] || w_grant[c_GNT_DRD]) begin
                        if (w_grant[c_GNT_DWR]) begin
                            r_state <= DWR;
                            r_wen   <= 1'b1;
                            r_store <= dstore;
                        end else begin
                            r_state <= DRD;
                            r_ren   <= 1'b1;
                        end
                        r_src  <= RESP_D;
                        r_addr <= daddr;
                        r_tcnt <= '0;
                        // Count data grants that overtake a waiting fetch.
                        if (iREN && (r_scnt != c_SCNT_MAX)) begin
                            r_scnt <= r_scnt + 1'b1;
                        end
                    end
                end

                IACC, DRD, DWR: begin
                    if (!w_req_held) begin
                        r_state <= IDLE;
                        r_ren   <= 1'b0;
                        r_wen   <= 1'b0;
                    end else if (w_rstate == ACCESS) begin
                        if (r_state == IACC) begin
                            iload <= ramload;
                        end
                        if (r_state == DRD) begin
                            dload <= ramload;
                        end
                        r_state <= RESP;
                        r_ren   <= 1'b0;
                        r_wen   <= 1'b0;
                    end else if (r_tcnt == c_TCNT_MAX) begin
                        timeout_err <= 1'b1;
                        r_state     <= IDLE;
                        r_ren       <= 1'b0;
                        r_wen       <= 1'b0;
                    end else begin
                        // BUSY, FREE and ERROR all keep the request driven;
                        // ERROR therefore re-issues the same access.
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end

                RESP: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                    r_ren   <= 1'b0;
                    r_wen   <= 1'b0;
                end
            endcase
        end
    end

endmodule : cache_mem_ctrl

`default_nettype wire
